// File: rtl/sorter_pkg.sv
// Shared definitions for the odd-even transposition sort slice.
// Contents:
//   WORD_W        data word width
//   word_t        one sort word
//   ctrl_state_t  stream controller FSM states
//   clog2()       index width helper, never narrower than one bit
package sorter_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    FILL,
    LOAD,
    SORT,
    CAPTURE,
    DRAIN
  } ctrl_state_t;

  // Width needed to index n items. Returns at least 1 so that the
  // degenerate cases still give a legal vector.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sort_stream_controller.sv
// Streaming front/back end for the N-lane systolic sorter.
// Collects up to N words from a valid/ready stream, pulses sort_load with
// the lanes presented on sort_data_flat, waits SORT_CYCLES cycles, captures
// sort_result_flat and then streams the N result lanes out, lane 0 first.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   s_valid/s_ready    input stream handshake
//   s_data, s_last     input word; s_last closes a short frame
//   m_valid/m_ready    output stream handshake
//   m_data, m_last     output word; m_last marks lane N-1
//   sort_load          one-cycle load strobe to the sorter
//   sort_data_flat     lanes to the sorter, lane i at [i*32 +: 32]
//   sort_result_flat   sorted lanes back from the sorter
//   busy               high in every state except FILL
module sort_stream_controller
  import sorter_pkg::*;
#(
  parameter int          N           = 8,
  parameter int          SORT_CYCLES = N,
  parameter logic [31:0] PAD_VALUE   = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [31:0]         s_data,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [31:0]         m_data,
  output logic                m_last,
  output logic                sort_load,
  output logic [N*WORD_W-1:0] sort_data_flat,
  input  logic [N*WORD_W-1:0] sort_result_flat,
  output logic                busy
);

  localparam int IDX_W = clog2(N);
  localparam int CNT_W = clog2(SORT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SORT_CYCLES - 1);

  ctrl_state_t      state;
  logic [IDX_W-1:0] fill_idx;
  logic [IDX_W-1:0] drain_idx;
  logic [CNT_W-1:0] sort_cnt;
  word_t            fill_buf [N];
  word_t            res_buf  [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      fill_idx  <= '0;
      drain_idx <= '0;
      sort_cnt  <= '0;
      // NOTE: both lane buffers are reset on purpose: lanes a short frame
      // never writes must read back as PAD_VALUE, so the storage itself
      // carries architectural reset state rather than being left as X.
      for (int i = 0; i < N; i++) begin
        fill_buf[i] <= PAD_VALUE;
        res_buf[i]  <= PAD_VALUE;
      end
    end else begin
      case (state)
        FILL: begin
          if (s_valid) begin
            fill_buf[fill_idx] <= s_data;
            // The index stays in range on the closing accept; CAPTURE
            // clears it before the next frame anyway.
            if (fill_idx == LAST_IDX || s_last) state <= LOAD;
            else                                fill_idx <= fill_idx + 1'b1;
          end
        end
        LOAD: begin
          sort_cnt <= '0;
          state    <= SORT;
        end
        SORT: begin
          if (sort_cnt == LAST_CNT) begin
            sort_cnt <= '0;
            state    <= CAPTURE;
          end else begin
            sort_cnt <= sort_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          // Results are taken and the fill side is re-padded on the same
          // edge, so the sorter input is clean before FILL reopens.
          for (int i = 0; i < N; i++) begin
            res_buf[i]  <= sort_result_flat[i*WORD_W +: WORD_W];
            fill_buf[i] <= PAD_VALUE;
          end
          fill_idx <= '0;
          state    <= DRAIN;
        end
        DRAIN: begin
          if (m_ready) begin
            if (drain_idx == LAST_IDX) begin
              drain_idx <= '0;
              state     <= FILL;
            end else begin
              drain_idx <= drain_idx + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Outputs decode straight from the state register. s_ready also
  // looks at rst so it is low for the whole reset cycle and high in the
  // very first cycle after release.
  assign s_ready   = (state == FILL) && !rst;
  assign sort_load = (state == LOAD);
  assign busy      = (state != FILL);
  assign m_valid   = (state == DRAIN);
  assign m_last    = (state == DRAIN) && (drain_idx == LAST_IDX);
  assign m_data    = res_buf[drain_idx];

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign sort_data_flat[g*WORD_W +: WORD_W] = fill_buf[g];
  end

endmodule
